three_band_mixer: RTL

Downstream combiner for the three biquad band filters (low, mid, high). On each sample strobe it captures the three band outputs and three per-band gains, then runs a time-multiplexed multiply-accumulate on a single signed multiplier over three cycles. It rounds and saturates the sum to 16 bits and presents one mixed sample to the output serializer with a one-cycle valid pulse.

---
 rtl/three_band_mixer_if.sv | 30 +++
 rtl/three_band_mixer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/three_band_mixer_if.sv
// Band-filter to mixer bus: three band samples, per-band Q2.14 gains and mute in;
// one mixed sample with valid/clip plus busy/overrun status out.
interface three_band_mixer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAIN_W = 16
);
  logic                     band_valid;
  logic signed [DATA_W-1:0] low_in;
  logic signed [DATA_W-1:0] mid_in;
  logic signed [DATA_W-1:0] high_in;
  logic signed [GAIN_W-1:0] gain_low;
  logic signed [GAIN_W-1:0] gain_mid;
  logic signed [GAIN_W-1:0] gain_high;
  logic                     mute;
  logic signed [DATA_W-1:0] mix_out;
  logic                     mix_valid;
  logic                     clip;
  logic                     busy;
  logic                     overrun;

  modport master (
    output band_valid, low_in, mid_in, high_in, gain_low, gain_mid, gain_high, mute,
    input  mix_out, mix_valid, clip, busy, overrun
  );

  modport slave (
    input  band_valid, low_in, mid_in, high_in, gain_low, gain_mid, gain_high, mute,
    output mix_out, mix_valid, clip, busy, overrun
  );
endinterface

// File: rtl/three_band_mixer.sv
// Three-band mixer: captures band samples and gains, runs a 3-cycle MAC on one shared
// multiplier, then rounds/saturates to DATA_W bits with a one-cycle valid pulse.
module three_band_mixer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAIN_W = 16,
  parameter int unsigned ACC_W  = 34
) (
  input logic               clk,
  input logic               reset,
  three_band_mixer_if.slave bus
);
  localparam int unsigned ProdW = DATA_W + GAIN_W;
  localparam int unsigned FracW = GAIN_W - 2;

  localparam logic signed [ACC_W-1:0] RndConst = {{(ACC_W-1){1'b0}}, 1'b1} << (FracW - 1);
  localparam logic signed [ACC_W-1:0] SatMax =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMac0, StMac1, StMac2, StOut} state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] low_q, mid_q, high_q, op_sample;
  logic signed [GAIN_W-1:0] g_low_q, g_mid_q, g_high_q, op_gain;
  logic                     mute_q;
  logic                     capture;

  logic signed [ProdW-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_q, acc_d, rounded, shifted;

  logic signed [DATA_W-1:0] mix_out_q, mix_out_d;
  logic                     mix_valid_q, mix_valid_d;
  logic                     clip_q, clip_d;
  logic                     overrun_q, overrun_d;

  // Single multiplier; operands chosen from the holding registers by MAC step.
  always_comb begin
    op_sample = low_q;
    op_gain   = g_low_q;
    case (state_q)
      StMac1: begin
        op_sample = mid_q;
        op_gain   = g_mid_q;
      end
      StMac2: begin
        op_sample = high_q;
        op_gain   = g_high_q;
      end
      default: ;
    endcase
  end

  assign prod     = ProdW'(op_sample) * ProdW'(op_gain);
  assign prod_ext = {{(ACC_W-ProdW){prod[ProdW-1]}}, prod};
  assign rounded  = acc_q + RndConst;
  assign shifted  = rounded >>> FracW;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    capture     = 1'b0;
    mix_valid_d = 1'b0;
    mix_out_d   = mix_out_q;
    clip_d      = clip_q;
    overrun_d   = overrun_q | (bus.band_valid && (state_q != StIdle));
    case (state_q)
      StIdle: begin
        if (bus.band_valid) begin
          capture = 1'b1;
          acc_d   = '0;
          state_d = StMac0;
        end
      end
      StMac0: begin
        acc_d   = acc_q + prod_ext;
        state_d = StMac1;
      end
      StMac1: begin
        acc_d   = acc_q + prod_ext;
        state_d = StMac2;
      end
      StMac2: begin
        acc_d   = acc_q + prod_ext;
        state_d = StOut;
      end
      StOut: begin
        mix_valid_d = 1'b1;
        state_d     = StIdle;
        if (mute_q) begin
          mix_out_d = '0;
          clip_d    = 1'b0;
        end else if (shifted > SatMax) begin
          mix_out_d = SatMax[DATA_W-1:0];
          clip_d    = 1'b1;
        end else if (shifted < SatMin) begin
          mix_out_d = SatMin[DATA_W-1:0];
          clip_d    = 1'b1;
        end else begin
          mix_out_d = shifted[DATA_W-1:0];
          clip_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      low_q       <= '0;
      mid_q       <= '0;
      high_q      <= '0;
      g_low_q     <= '0;
      g_mid_q     <= '0;
      g_high_q    <= '0;
      mute_q      <= 1'b0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
      if (capture) begin
        low_q    <= bus.low_in;
        mid_q    <= bus.mid_in;
        high_q   <= bus.high_in;
        g_low_q  <= bus.gain_low;
        g_mid_q  <= bus.gain_mid;
        g_high_q <= bus.gain_high;
        mute_q   <= bus.mute;
      end
    end
  end

  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.clip      = clip_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.overrun   = overrun_q;
endmodule
